// File: rtl/cpack_decompressor.sv
// C-Pack line decompressor: parses MSB-first variable-length codes out of
// 64-bit beats and rebuilds 32-bit words using a 16-entry FIFO dictionary
// that tracks the compressor's dictionary push for push.
module cpack_decompressor #(
    parameter int WIDTH      = 64,
    parameter int WORD       = 32,
    parameter int DICT_ENTRY = 16,
    parameter int CACHE_LINE = 128
) (
    input  logic                       i_clk,
    input  logic                       i_reset,
    input  logic [WIDTH-1:0]           i_data,
    input  logic                       i_valid,
    output logic                       o_ready,
    input  logic                       i_sop,
    input  logic                       i_raw,
    output logic [WORD-1:0]            o_word,
    output logic                       o_valid,
    input  logic                       i_ready,
    output logic                       o_last,
    output logic                       o_error,
    output logic [DICT_ENTRY*WORD-1:0] o_dictionary_data
);
    localparam int BUF_W          = 2 * WIDTH;
    localparam int WORDS_PER_LINE = CACHE_LINE / WORD;

    typedef enum logic [1:0] {S_IDLE, S_CMP, S_PAD, S_RAW} state_t;

    state_t           state_q, state_d;
    logic [BUF_W-1:0] buf_q, buf_d;
    logic [7:0]       cnt_q, cnt_d;
    logic [1:0]       widx_q, widx_d;
    logic [7:0]       lbits_q, lbits_d;
    logic [5:0]       pad_q, pad_d;
    logic [3:0]       wptr_q, wptr_d;
    logic [WORD-1:0]  o_word_q, o_word_d;
    logic             o_valid_q, o_valid_d;
    logic             o_last_q, o_last_d;
    logic             err_q, err_d;
    logic [WORD-1:0]  dict_q [DICT_ENTRY];

    // code parser outputs
    logic [1:0]       pre2;
    logic [3:0]       idx_a, idx_b;
    logic [WORD-1:0]  entry_a, entry_b;
    logic [7:0]       code_len;
    logic [WORD-1:0]  code_word;
    logic             code_push;
    logic             code_illegal;

    // control
    logic             accept, out_free, decodable, drop_beat, flush;
    logic             push_en;
    logic [WORD-1:0]  push_word;
    logic [7:0]       consume, cnt_mid, lbits_new;
    logic [BUF_W-1:0] shifted;

    assign accept   = i_valid && o_ready;
    assign out_free = !o_valid_q || i_ready;
    assign pre2     = buf_q[BUF_W-1 -: 2];
    assign idx_a    = buf_q[BUF_W-3 -: 4];
    assign idx_b    = buf_q[BUF_W-5 -: 4];
    assign entry_a  = dict_q[idx_a];
    assign entry_b  = dict_q[idx_b];

    // Decode the code sitting at the top of the bit buffer
    always_comb begin
        code_len     = 8'd2;
        code_word    = '0;
        code_push    = 1'b0;
        code_illegal = 1'b0;
        case (pre2)
            2'b00: code_len = 8'd2;
            2'b01: begin
                code_len  = 8'd34;
                code_word = buf_q[BUF_W-3 -: 32];
                code_push = 1'b1;
            end
            2'b10: begin
                code_len  = 8'd6;
                code_word = entry_a;
            end
            default: begin
                case (buf_q[BUF_W-3 -: 2])
                    2'b00: begin
                        code_len  = 8'd24;
                        code_word = {entry_b[31:16], buf_q[BUF_W-9 -: 16]};
                        code_push = 1'b1;
                    end
                    2'b01: begin
                        code_len  = 8'd12;
                        code_word = {24'b0, buf_q[BUF_W-5 -: 8]};
                    end
                    2'b10: begin
                        code_len  = 8'd16;
                        code_word = {entry_b[31:8], buf_q[BUF_W-9 -: 8]};
                        code_push = 1'b1;
                    end
                    default: begin
                        code_len     = 8'd4;
                        code_illegal = 1'b1;
                    end
                endcase
            end
        endcase
    end

    assign decodable = (cnt_q >= 8'd2) && ((pre2 != 2'b11) || (cnt_q >= 8'd4));

    // Next-state, output and buffer bookkeeping
    always_comb begin
        state_d   = state_q;
        widx_d    = widx_q;
        lbits_d   = lbits_q;
        pad_d     = pad_q;
        o_word_d  = o_word_q;
        o_valid_d = o_valid_q;
        o_last_d  = o_last_q;
        err_d     = err_q;
        push_en   = 1'b0;
        push_word = code_word;
        consume   = 8'd0;
        drop_beat = 1'b0;
        flush     = 1'b0;
        lbits_new = lbits_q + code_len;

        if (o_valid_q && i_ready) begin
            o_valid_d = 1'b0;
            o_last_d  = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (i_sop) begin
                        state_d = i_raw ? S_RAW : S_CMP;
                        widx_d  = 2'd0;
                        lbits_d = 8'd0;
                    end else begin
                        err_d     = 1'b1;
                        drop_beat = 1'b1;
                    end
                end
            end
            S_CMP: begin
                if (accept && i_sop) err_d = 1'b1;
                if (decodable && code_illegal) begin
                    err_d   = 1'b1;
                    flush   = 1'b1;
                    state_d = S_IDLE;
                end else if (decodable && (cnt_q >= code_len) && out_free) begin
                    consume   = code_len;
                    o_word_d  = code_word;
                    o_valid_d = 1'b1;
                    o_last_d  = (widx_q == 2'(WORDS_PER_LINE - 1));
                    push_en   = code_push;
                    widx_d    = widx_q + 2'd1;
                    lbits_d   = lbits_new;
                    if (widx_q == 2'(WORDS_PER_LINE - 1)) begin
                        // realign to the next beat boundary
                        pad_d   = 6'd0 - lbits_new[5:0];
                        state_d = S_PAD;
                    end
                end
            end
            S_PAD: begin
                if (accept && i_sop) err_d = 1'b1;
                if (cnt_q >= {2'b00, pad_q}) begin
                    consume = {2'b00, pad_q};
                    state_d = S_IDLE;
                end
            end
            default: begin // S_RAW
                if (accept && i_sop) err_d = 1'b1;
                if ((cnt_q >= 8'd32) && out_free) begin
                    consume   = 8'd32;
                    o_word_d  = buf_q[BUF_W-1 -: WORD];
                    o_valid_d = 1'b1;
                    o_last_d  = (widx_q == 2'(WORDS_PER_LINE - 1));
                    widx_d    = widx_q + 2'd1;
                    if (widx_q == 2'(WORDS_PER_LINE - 1)) state_d = S_IDLE;
                end
            end
        endcase

        // consume from the top, then append the accepted beat right below
        shifted = buf_q << consume;
        cnt_mid = cnt_q - consume;
        if (flush) begin
            buf_d = '0;
            cnt_d = 8'd0;
        end else if (accept && !drop_beat) begin
            buf_d = shifted | ({i_data, {WIDTH{1'b0}}} >> cnt_mid);
            cnt_d = cnt_mid + 8'd64;
        end else begin
            buf_d = shifted;
            cnt_d = cnt_mid;
        end

        wptr_d = push_en ? wptr_q + 4'd1 : wptr_q;
    end

    // Control, buffer and output registers
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state_q   <= S_IDLE;
            buf_q     <= '0;
            cnt_q     <= 8'd0;
            widx_q    <= 2'd0;
            lbits_q   <= 8'd0;
            pad_q     <= 6'd0;
            wptr_q    <= 4'd0;
            o_word_q  <= '0;
            o_valid_q <= 1'b0;
            o_last_q  <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            buf_q     <= buf_d;
            cnt_q     <= cnt_d;
            widx_q    <= widx_d;
            lbits_q   <= lbits_d;
            pad_q     <= pad_d;
            wptr_q    <= wptr_d;
            o_word_q  <= o_word_d;
            o_valid_q <= o_valid_d;
            o_last_q  <= o_last_d;
            err_q     <= err_d;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < DICT_ENTRY; gi++) begin : g_dict
            // Dictionary entry written when the push pointer lands on it
            always_ff @(posedge i_clk or negedge i_reset) begin
                if (!i_reset) begin
                    dict_q[gi] <= '0;
                end else if (push_en && (wptr_q == 4'(gi))) begin
                    dict_q[gi] <= push_word;
                end
            end
            assign o_dictionary_data[WORD*gi +: WORD] = dict_q[gi];
        end
    endgenerate

    assign o_ready = (cnt_q <= 8'd64);
    assign o_word  = o_word_q;
    assign o_valid = o_valid_q;
    assign o_last  = o_last_q;
    assign o_error = err_q;
endmodule

// File: tb/tb_cpack_decompressor.sv
// Scoreboard bench for cpack_decompressor: stimulus queues hand-computed
// words, a monitor pops and compares on every output handshake.
module tb_cpack_decompressor;
    logic         i_clk = 1'b0;
    logic         i_reset = 1'b0;
    logic [63:0]  i_data = '0;
    logic         i_valid = 1'b0;
    logic         o_ready;
    logic         i_sop = 1'b0;
    logic         i_raw = 1'b0;
    logic [31:0]  o_word;
    logic         o_valid;
    logic         i_ready = 1'b1;
    logic         o_last;
    logic         o_error;
    logic [511:0] o_dictionary_data;

    int n_pass = 0;
    int n_total = 0;
    int n_popped = 0;
    bit saw_not_ready = 1'b0;
    logic [32:0] exp_q[$];

    cpack_decompressor dut (
        .i_clk(i_clk), .i_reset(i_reset), .i_data(i_data), .i_valid(i_valid),
        .o_ready(o_ready), .i_sop(i_sop), .i_raw(i_raw), .o_word(o_word),
        .o_valid(o_valid), .i_ready(i_ready), .o_last(o_last),
        .o_error(o_error), .o_dictionary_data(o_dictionary_data)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic expect_word(input logic [31:0] w, input logic last);
        exp_q.push_back({last, w});
    endtask

    // Monitor: one comparison per transferred word
    always @(negedge i_clk) begin
        if (i_reset && o_valid && i_ready) begin
            if (exp_q.size() == 0) begin
                n_total++;
                $display("FAIL unexpected_word: got %08h, expected none", o_word);
            end else begin
                logic [32:0] e;
                e = exp_q.pop_front();
                $display("word %0d: %08h last=%0b", n_popped, o_word, o_last);
                check($sformatf("word%0d", n_popped), 512'(o_word), 512'(e[31:0]));
                check($sformatf("last%0d", n_popped), 512'(o_last), 512'(e[32]));
            end
            n_popped++;
        end
    end

    // Present one beat; called and returns at posedge+1
    task automatic send_beat(input logic [63:0] d, input logic sop, input logic raw);
        int t;
        t = 0;
        i_data = d; i_sop = sop; i_raw = raw; i_valid = 1'b1;
        @(negedge i_clk);
        while (!o_ready && t < 200) begin
            saw_not_ready = 1'b1;
            t++;
            @(negedge i_clk);
        end
        if (!o_ready) check("beat_accept_timeout", 512'(o_ready), 512'(1));
        @(posedge i_clk); #1;
        i_valid = 1'b0; i_sop = 1'b0; i_raw = 1'b0;
    endtask

    task automatic send_line(input logic [191:0] v, input int nb, input logic raw);
        for (int i = 0; i < nb; i++) send_beat(v[191-64*i -: 64], (i == 0), raw);
    endtask

    task automatic wait_pops(input int target);
        int t;
        t = 0;
        while (n_popped < target && t < 1000) begin
            @(negedge i_clk);
            t++;
        end
        if (n_popped < target) check("word_timeout", 512'(n_popped), 512'(target));
        repeat (2) @(posedge i_clk);
        #1;
    endtask

    localparam logic [511:0] DICT_FINAL = {
        32'hCAFEF00D, 32'hEEEE0077, 32'hDDDDDEF0, 32'hCCCC9ABC,
        32'hBBBB5678, 32'hAAAA1234, 32'h22220008, 32'h11110007,
        32'hFFFF0006, 32'hEEEE0005, 32'hDDDD0004, 32'hCCCC0003,
        32'hBBBB0002, 32'hAAAA0001, 32'h123456AB, 32'h0BADBEEF};

    initial begin
        int base;
        #12;
        check("rst_valid", 512'(o_valid), 512'(0));
        check("rst_last", 512'(o_last), 512'(0));
        check("rst_error", 512'(o_error), 512'(0));
        check("rst_word", 512'(o_word), 512'(0));
        check("rst_ready", 512'(o_ready), 512'(1));
        check("rst_dict", o_dictionary_data, 512'(0));
        i_reset = 1'b1;
        @(posedge i_clk); #1;

        // Line 1: zero, literal, full match, mmmx
        expect_word(32'h00000000, 0); expect_word(32'h12345678, 0);
        expect_word(32'h12345678, 0); expect_word(32'h123456AB, 1);
        send_line({2'b00, 2'b01, 32'h12345678, 2'b10, 4'h0, 4'b1110, 4'h0, 8'hAB, 6'b0, 128'b0}, 1, 0);
        wait_pops(4);
        check("l1_dict01", 512'(o_dictionary_data[63:0]), 512'({32'h123456AB, 32'h12345678}));

        // Line 2: four literals over three beats, 56 pad bits
        saw_not_ready = 1'b0;
        expect_word(32'hAAAA0001, 0); expect_word(32'hBBBB0002, 0);
        expect_word(32'hCCCC0003, 0); expect_word(32'hDDDD0004, 1);
        send_line({2'b01, 32'hAAAA0001, 2'b01, 32'hBBBB0002, 2'b01, 32'hCCCC0003,
                   2'b01, 32'hDDDD0004, 56'b0}, 3, 0);
        wait_pops(8);
        check("l2_not_ready_seen", 512'(saw_not_ready), 512'(1));

        // Line 3: four literals with a 5-cycle downstream stall
        base = n_popped;
        expect_word(32'hEEEE0005, 0); expect_word(32'hFFFF0006, 0);
        expect_word(32'h11110007, 0); expect_word(32'h22220008, 1);
        fork
            send_line({2'b01, 32'hEEEE0005, 2'b01, 32'hFFFF0006, 2'b01, 32'h11110007,
                       2'b01, 32'h22220008, 56'b0}, 3, 0);
            begin
                int t;
                t = 0;
                while (n_popped < base + 1 && t < 500) begin
                    @(posedge i_clk); #1;
                    t++;
                end
                i_ready = 1'b0;
                for (int k = 0; k < 5; k++) begin
                    @(negedge i_clk);
                    check($sformatf("stall_valid%0d", k), 512'(o_valid), 512'(1));
                    check($sformatf("stall_word%0d", k), 512'(o_word), 512'(32'hFFFF0006));
                end
                @(posedge i_clk); #1;
                i_ready = 1'b1;
            end
        join
        wait_pops(base + 4);

        // Line 4: four mmxx codes
        expect_word(32'hAAAA1234, 0); expect_word(32'hBBBB5678, 0);
        expect_word(32'hCCCC9ABC, 0); expect_word(32'hDDDDDEF0, 1);
        send_line({4'b1100, 4'd2, 16'h1234, 4'b1100, 4'd3, 16'h5678, 4'b1100, 4'd4, 16'h9ABC,
                   4'b1100, 4'd5, 16'hDEF0, 32'b0, 64'b0}, 2, 0);
        wait_pops(16);

        // Line 5: zzzx, mmmx, two literals; the 17th push wraps onto entry 0
        expect_word(32'h0000005A, 0); expect_word(32'hEEEE0077, 0);
        expect_word(32'hCAFEF00D, 0); expect_word(32'h0BADBEEF, 1);
        send_line({4'b1101, 8'h5A, 4'b1110, 4'd6, 8'h77, 2'b01, 32'hCAFEF00D,
                   2'b01, 32'h0BADBEEF, 32'b0, 64'b0}, 2, 0);
        wait_pops(20);
        check("wrap_dict0", 512'(o_dictionary_data[31:0]), 512'(32'h0BADBEEF));

        // Line 6: full matches on the wrapped entries
        expect_word(32'h0BADBEEF, 0); expect_word(32'hCAFEF00D, 0);
        expect_word(32'h00000000, 0); expect_word(32'h123456AB, 1);
        send_line({2'b10, 4'd0, 2'b10, 4'd15, 2'b00, 2'b10, 4'd1, 44'b0, 128'b0}, 1, 0);
        wait_pops(24);
        check("dict_full", o_dictionary_data, DICT_FINAL);

        // Line 7: raw line leaves the dictionary alone
        expect_word(32'h11111111, 0); expect_word(32'h22222222, 0);
        expect_word(32'h33333333, 0); expect_word(32'h44444444, 1);
        send_line({64'h11111111_22222222, 64'h33333333_44444444, 64'b0}, 2, 1);
        wait_pops(28);
        check("raw_dict", o_dictionary_data, DICT_FINAL);
        check("no_error_yet", 512'(o_error), 512'(0));

        // Line 8: illegal prefix
        send_line({4'b1111, 188'b0}, 1, 0);
        repeat (4) @(posedge i_clk);
        #1;
        check("illegal_error", 512'(o_error), 512'(1));
        check("illegal_no_word", 512'(n_popped), 512'(28));

        // Line 9: decoding resumes after the drop, error stays set
        expect_word(32'hAAAA0001, 0); expect_word(32'h00000000, 0);
        expect_word(32'h00000000, 0); expect_word(32'h00000000, 1);
        send_line({2'b10, 4'd2, 2'b00, 2'b00, 2'b00, 52'b0, 128'b0}, 1, 0);
        wait_pops(32);
        check("error_sticky", 512'(o_error), 512'(1));

        // Async reset in the middle of a line
        i_ready = 1'b0;
        send_beat(64'h0, 1'b1, 1'b0);
        send_beat({2'b01, 32'hAAAA0001, 30'b0}, 1'b1, 1'b0);
        repeat (3) @(negedge i_clk);
        check("pre_rst_valid", 512'(o_valid), 512'(1));
        check("pre_rst_word", 512'(o_word), 512'(32'h00000000));
        #2;
        i_reset = 1'b0;
        #1;
        check("mid_rst_valid", 512'(o_valid), 512'(0));
        check("mid_rst_error", 512'(o_error), 512'(0));
        check("mid_rst_word", 512'(o_word), 512'(0));
        check("mid_rst_last", 512'(o_last), 512'(0));
        check("mid_rst_ready", 512'(o_ready), 512'(1));
        check("mid_rst_dict", o_dictionary_data, 512'(0));
        #20;
        i_reset = 1'b1;
        i_ready = 1'b1;
        repeat (3) @(posedge i_clk);
        #1;
        check("post_rst_idle", 512'(o_valid), 512'(0));
        check("queue_drained", 512'(exp_q.size()), 512'(0));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
